// File: rtl/ascii_codes_pkg.sv
// rtl/ascii_codes_pkg.sv - shared ASCII constants and types for the digit parsers
//
// Purpose: character-class bounds, the digit-pair assembler state encoding and
// the packed {tens, ones} character pair handed to the ASCII-to-binary decoder.
// Ports: none (package).
package ascii_codes_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ONE  = 3'd1,
    ST_TWO  = 3'd2,
    ST_SKIP = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] tens;
    logic [7:0] ones;
  } ascii_pair_t;

endpackage

// File: rtl/ascii_is_digit.sv
// rtl/ascii_is_digit.sv - combinational ASCII decimal-digit classifier
//
// Purpose: flags bytes '0'..'9'; every other value, including 0x00 and
// 0x80-0xFF, is a non-digit.
// Ports:
//   i_char     in  8  ASCII character
//   o_is_digit out 1  high when i_char is in 0x30..0x39
module ascii_is_digit
  import ascii_codes_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_digit
);

  assign o_is_digit = (i_char >= ASCII_ZERO) && (i_char <= ASCII_NINE);

endmodule

// File: rtl/ascii_digit_pair_assembler.sv
// rtl/ascii_digit_pair_assembler.sv - groups ASCII digits into packed {tens, ones} tokens
//
// Purpose: byte-serial front end for the ASCII-to-binary decoder. Runs of
// decimal digits terminated by any non-digit become one 16-bit token. One
// digit is padded with p_pad in the tens byte; more than two digits yields a
// zero payload with out_err set.
// Ports:
//   clk      in  1   clock
//   rst      in  1   synchronous active-high reset
//   in_val   in  1   input byte valid
//   in_rdy   out 1   byte accepted this cycle when high (state based only)
//   in_      in  8   ASCII character
//   out_val  out 1   packed token valid
//   out_rdy  in  1   downstream accepts token
//   out      out 16  {tens_char, ones_char}
//   out_err  out 1   token was longer than two digits
module ascii_digit_pair_assembler
  import ascii_codes_pkg::*;
#(
  parameter logic [7:0] p_pad = 8'h30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [15:0] out,
  output logic        out_err
);

  state_t      r_state;
  logic [7:0]  r_d0;
  logic [7:0]  r_d1;
  ascii_pair_t r_out;
  logic        r_out_err;

  logic        w_is_digit;
  logic        w_accept;

  ascii_is_digit u_is_digit (
    .i_char     (in_),
    .o_is_digit (w_is_digit)
  );

  // in_rdy depends on state alone so there is no out_rdy -> in_rdy path.
  assign in_rdy   = (r_state != ST_SEND);
  assign w_accept = in_val && in_rdy;

  assign out_val  = (r_state == ST_SEND);
  assign out      = r_out;
  assign out_err  = r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_d0      <= 8'h00;
      r_d1      <= 8'h00;
      r_out     <= '0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Delimiters here are absorbed: leading/repeated separators emit nothing.
          if (w_accept && w_is_digit) begin
            r_d0    <= in_;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept) begin
            if (w_is_digit) begin
              r_d1    <= in_;
              r_state <= ST_TWO;
            end else begin
              r_out.tens <= p_pad;
              r_out.ones <= r_d0;
              r_out_err  <= 1'b0;
              r_state    <= ST_SEND;
            end
          end
        end
        ST_TWO: begin
          if (w_accept) begin
            if (w_is_digit) begin
              r_state <= ST_SKIP;
            end else begin
              r_out.tens <= r_d0;
              r_out.ones <= r_d1;
              r_out_err  <= 1'b0;
              r_state    <= ST_SEND;
            end
          end
        end
        ST_SKIP: begin
          // Overlong token: swallow digits until the delimiter, then report
          // a zero payload the decoder maps to 0.
          if (w_accept && !w_is_digit) begin
            r_out     <= '0;
            r_out_err <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_rdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_digit_pair_assembler.sv
// tb/tb_ascii_digit_pair_assembler.sv - directed self-checking bench for ascii_digit_pair_assembler
module tb_ascii_digit_pair_assembler;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] out;
  logic        out_err;

  int vectors;
  int miscompares;

  logic [15:0] q_data[$];
  logic        q_err[$];

  ascii_digit_pair_assembler #(.p_pad(8'h30)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_     (in_),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out),
    .out_err (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token collector: records every output handshake.
  always @(posedge clk) begin
    if (!rst && out_val && out_rdy) begin
      q_data.push_back(out);
      q_err.push_back(out_err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_val = 1'b1;
    in_    = b;
    n      = 0;
    while (!in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte=%h in_rdy=%b required 1", b, in_rdy);
    end
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_err.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_ = 8'h00; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (out_val !== 1'b0) begin miscompares++; $display("FAIL reset_out_val got %b want 0", out_val); end
    vectors++;
    if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err got %b want 0", out_err); end
    vectors++;
    if (out !== 16'h0000) begin miscompares++; $display("FAIL reset_out got %h want 0000", out); end
    vectors++;
    if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
  endtask

  task automatic test_single_digit();
    clear_q();
    out_rdy = 1'b1;
    send_byte(8'h37);
    in_val = 1'b1; in_ = 8'h0A;
    vectors++;
    if (out_val !== 1'b0) begin miscompares++; $display("FAIL single_early_val got %b want 0", out_val); end
    @(posedge clk); #1;
    in_val = 1'b0;
    vectors++;
    if (out_val !== 1'b1) begin miscompares++; $display("FAIL single_latency out_val got %b want 1", out_val); end
    @(posedge clk); #1;
    vectors++;
    if (out_val !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle out_val got %b want 0", out_val); end
    drain();
    vectors++;
    if (q_data.size() !== 1) begin
      miscompares++; $display("FAIL single_count got %0d want 1", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h3037 || q_err[0] !== 1'b0) begin
        miscompares++; $display("FAIL single_data got %h err %b want 3037 err 0", q_data[0], q_err[0]);
      end
    end
  endtask

  task automatic test_two_digit();
    clear_q();
    out_rdy = 1'b1;
    send_byte(8'h31); send_byte(8'h39); send_byte(8'h20);
    drain();
    vectors++;
    if (q_data.size() !== 1) begin
      miscompares++; $display("FAIL pair_count got %0d want 1", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h3139 || q_err[0] !== 1'b0) begin
        miscompares++; $display("FAIL pair_data got %h err %b want 3139 err 0", q_data[0], q_err[0]);
      end
    end
  endtask

  task automatic test_overlong();
    clear_q();
    out_rdy = 1'b1;
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h20);
    send_byte(8'h35); send_byte(8'h20);
    drain();
    vectors++;
    if (q_data.size() !== 2) begin
      miscompares++; $display("FAIL overlong_count got %0d want 2", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h0000 || q_err[0] !== 1'b1) begin
        miscompares++; $display("FAIL overlong_err_tok got %h err %b want 0000 err 1", q_data[0], q_err[0]);
      end
      vectors++;
      if (q_data[1] !== 16'h3035 || q_err[1] !== 1'b0) begin
        miscompares++; $display("FAIL overlong_next_tok got %h err %b want 3035 err 0", q_data[1], q_err[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_rdy = 1'b0;
    send_byte(8'h34); send_byte(8'h32); send_byte(8'h20);
    in_val = 1'b1; in_ = 8'h38;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || out !== 16'h3432 || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d val %b rdy %b out %h err %b want 1 0 3432 0",
                 i, out_val, in_rdy, out, out_err);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
      miscompares++; $display("FAIL stall_release val %b rdy %b want 0 1", out_val, in_rdy);
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    send_byte(8'h20);
    drain();
    vectors++;
    if (q_data.size() !== 2) begin
      miscompares++; $display("FAIL stall_count got %0d want 2", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h3432 || q_data[1] !== 16'h3038) begin
        miscompares++; $display("FAIL stall_data got %h %h want 3432 3038", q_data[0], q_data[1]);
      end
    end
  endtask

  task automatic test_delimiters();
    clear_q();
    out_rdy = 1'b1;
    send_byte(8'h20); send_byte(8'h20); send_byte(8'h0A); send_byte(8'h0A);
    send_byte(8'h00); send_byte(8'hB5);
    drain();
    vectors++;
    if (q_data.size() !== 0) begin
      miscompares++; $display("FAIL delim_only_count got %0d want 0", q_data.size());
    end
    send_byte(8'h34); send_byte(8'h20);
    drain();
    vectors++;
    if (q_data.size() !== 1) begin
      miscompares++; $display("FAIL delim_count got %0d want 1", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h3034 || q_err[0] !== 1'b0) begin
        miscompares++; $display("FAIL delim_data got %h err %b want 3034 err 0", q_data[0], q_err[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_q();
    out_rdy = 1'b1;
    send_byte(8'h34);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (out_val !== 1'b0 || out_err !== 1'b0) begin
      miscompares++; $display("FAIL midreset_out val %b err %b want 0 0", out_val, out_err);
    end
    send_byte(8'h38); send_byte(8'h20);
    drain();
    vectors++;
    if (q_data.size() !== 1) begin
      miscompares++; $display("FAIL midreset_count got %0d want 1", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 16'h3038 || q_err[0] !== 1'b0) begin
        miscompares++; $display("FAIL midreset_data got %h err %b want 3038 err 0", q_data[0], q_err[0]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_val      = 1'b0;
    in_         = 8'h00;
    out_rdy     = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_digit();
    test_two_digit();
    test_overlong();
    test_backpressure();
    test_delimiters();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
